// File: rtl/global_barrier_pkg.sv
// Shared types and default sizes for the global barrier unit.
package global_barrier_pkg;

  localparam int NUM_TILES_DEF = 4;
  localparam int TMO_W_DEF     = 16;
  localparam int CNT_W_DEF     = 16;

  // Barrier lifecycle: wait for a first request, collect the rest,
  // wait for requests to drop after release, or hold after a timeout.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

endpackage

// File: rtl/global_barrier_unit_timer.sv
// Gather timeout timer: loaded to 1 at barrier start together with the
// timeout limit, counts gather cycles, and flags expiry once the count
// reaches the limit. A zero limit never expires.
module barrier_timeout_timer #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic [TMO_W-1:0] tmo_in,
  output logic             expired
);

  logic [TMO_W-1:0] timer_q;
  logic [TMO_W-1:0] tmo_q;

  // Load on barrier start; count while gathering, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
      tmo_q   <= '0;
    end else if (load) begin
      timer_q <= TMO_W'(1);
      tmo_q   <= tmo_in;
    end else if (inc && (timer_q != '1)) begin
      timer_q <= timer_q + TMO_W'(1);
    end
  end

  assign expired = (tmo_q != '0) && (timer_q >= tmo_q);

endmodule

// File: rtl/global_barrier_unit.sv
// Global barrier responder: gathers per-tile sync requests, releases all
// participants with a simultaneous one-cycle grant, counts completed
// barriers, and reports tiles that fail to arrive before a timeout.
//
// Handshake: a tile raises sync_request (level) and holds it until it sees
// its one-cycle sync_grant; after a grant the tile must drop its request
// before the unit will start another barrier (DRAIN).
module global_barrier_unit
  import global_barrier_pkg::*;
#(
  parameter int NUM_TILES = NUM_TILES_DEF,
  parameter int TMO_W     = TMO_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_TILES-1:0] participant_mask,
  input  logic [TMO_W-1:0]     timeout_cycles,
  input  logic                 clear_err,
  input  logic [NUM_TILES-1:0] sync_request,
  output logic [NUM_TILES-1:0] sync_grant,
  output logic                 global_sync_out,
  output logic                 barrier_active,
  output logic [CNT_W-1:0]     barrier_count,
  output logic                 timeout_err,
  output logic [NUM_TILES-1:0] missing_mask,
  output logic [NUM_TILES-1:0] stray_mask
);

  state_t               state_q, state_d;
  logic [NUM_TILES-1:0] arrived_q, arrived_d;
  logic [NUM_TILES-1:0] mask_q, mask_d;
  logic [NUM_TILES-1:0] grant_q, grant_d;
  logic                 gso_q, gso_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;
  logic [NUM_TILES-1:0] missing_q, missing_d;
  logic [NUM_TILES-1:0] stray_q, stray_d;

  logic                 tmr_load;
  logic                 tmr_inc;
  logic                 tmr_expired;

  logic [NUM_TILES-1:0] req_in;
  logic [NUM_TILES-1:0] acc;
  logic                 complete;
  logic [NUM_TILES-1:0] start_req;

  barrier_timeout_timer #(
    .TMO_W (TMO_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .inc     (tmr_inc),
    .tmo_in  (timeout_cycles),
    .expired (tmr_expired)
  );

  // Arrival view for this edge: latched arrivals plus live participant requests.
  assign req_in    = sync_request & mask_q;
  assign acc       = arrived_q | req_in;
  assign complete  = (acc == mask_q);
  assign start_req = sync_request & participant_mask;

  // Next-state and next-register values for the barrier FSM.
  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    mask_d    = mask_q;
    grant_d   = '0;
    gso_d     = 1'b0;
    count_d   = count_q;
    err_d     = err_q;
    missing_d = missing_q;
    stray_d   = stray_q;
    tmr_load  = 1'b0;
    tmr_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && (participant_mask != '0)) begin
          stray_d = stray_q | (sync_request & ~participant_mask);
          if (start_req != '0) begin
            mask_d    = participant_mask;
            arrived_d = start_req;
            tmr_load  = 1'b1;
            if (start_req == participant_mask) begin
              grant_d = participant_mask;
              gso_d   = 1'b1;
              count_d = count_q + CNT_W'(1);
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_GATHER;
            end
          end
        end
      end

      ST_GATHER: begin
        stray_d = stray_q | (sync_request & ~mask_q);
        if (!enable) begin
          // Abort: drop arrivals, no grant, count untouched.
          arrived_d = '0;
          state_d   = ST_IDLE;
        end else begin
          arrived_d = acc;
          tmr_inc   = 1'b1;
          if (complete) begin
            // Completion beats a timeout expiring on the same edge.
            grant_d = mask_q;
            gso_d   = 1'b1;
            count_d = count_q + CNT_W'(1);
            state_d = ST_DRAIN;
          end else if (tmr_expired) begin
            missing_d = mask_q & ~acc;
            err_d     = 1'b1;
            state_d   = ST_ERROR;
          end
        end
      end

      ST_DRAIN: begin
        // Held requests after the grant must not count toward the next barrier.
        stray_d = stray_q | (sync_request & ~mask_q);
        if (req_in == '0) begin
          arrived_d = '0;
          state_d   = ST_IDLE;
        end
      end

      ST_ERROR: begin
        stray_d = stray_q | (sync_request & ~mask_q);
        if (clear_err) begin
          err_d     = 1'b0;
          missing_d = '0;
          arrived_d = '0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear_err) begin
      stray_d = '0;
    end
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      arrived_q <= '0;
      mask_q    <= '0;
      grant_q   <= '0;
      gso_q     <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
      missing_q <= '0;
      stray_q   <= '0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      mask_q    <= mask_d;
      grant_q   <= grant_d;
      gso_q     <= gso_d;
      count_q   <= count_d;
      err_q     <= err_d;
      missing_q <= missing_d;
      stray_q   <= stray_d;
    end
  end

  assign sync_grant      = grant_q;
  assign global_sync_out = gso_q;
  assign barrier_active  = (state_q == ST_GATHER) || (state_q == ST_DRAIN);
  assign barrier_count   = count_q;
  assign timeout_err     = err_q;
  assign missing_mask    = missing_q;
  assign stray_mask      = stray_q;

endmodule
